// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the pipeline memory slice.
// Arbiter FSM states, requester owner codes and memory direction codes.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with a zero flag.
// Loads LAT-1 and holds at zero once it gets there.
module wait_counter #(
    parameter int LAT = 2,
    localparam int W = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LAT - 1);
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and memory stage.
// Data wins by default; a saturating counter bounds fetch starvation.
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SW = $clog2(STARVE + 1);

    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          we_q;
    logic [SW-1:0] starve_q;
    logic          starve_full;
    logic          sel_dm;
    logic          grant;
    logic          capture;
    logic          wc_load;
    logic          wc_dec;
    logic          wc_zero;

    assign starve_full = (starve_q == SW'(STARVE));
    assign sel_dm      = dm_req & ~(if_req & starve_full);

    wait_counter #(
        .LAT (LAT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wc_load),
        .dec   (wc_dec),
        .zero  (wc_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        capture = 1'b0;
        wc_load = 1'b0;
        wc_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    wc_load = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wc_dec = 1'b1;
                if (wc_zero) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The mem_* registers double as the request latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            starve_q  <= '0;
            mem_en    <= 1'b0;
            mem_rw    <= MEM_RD;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (grant) begin
                owner_q   <= sel_dm ? OWN_DM : OWN_IF;
                we_q      <= sel_dm & dm_we;
                mem_en    <= 1'b1;
                mem_rw    <= (sel_dm & dm_we) ? MEM_WR : MEM_RD;
                mem_addr  <= sel_dm ? dm_addr : if_addr;
                mem_wdata <= sel_dm ? dm_wdata : '0;
                if (!sel_dm) begin
                    starve_q <= '0;
                end else if (if_req && !starve_full) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
            if (capture) begin
                if (owner_q == OWN_DM) begin
                    dm_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
            if (state_d == ST_RESP) begin
                if (owner_q == OWN_DM) begin
                    dm_ack <= 1'b1;
                end else begin
                    if_ack <= 1'b1;
                end
            end
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the five-stage pipeline processor. It shares one unified memory between the fetch stage (read-only) and the memory stage (read/write), and produces per-requester stall signals for the pipeline registers. It sits between the PC/IR fetch logic, the memory-stage control (mem_en/rw from the CU), and a fixed-latency memory macro.

## Interface
- ADDR_W, 21: memory address width.
- DATA_W, 16: memory word width.
- LAT, 2: memory read latency in cycles. Legal range is LAT ≥ 1.
- STARVE, 4: maximum consecutive data grants while fetch is waiting.

- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  data read data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid LAT cycles after the mem_en cycle.
- stall_if  out  1  if_req & ~if_ack; combinational.
- stall_mem  out  1  dm_req & ~dm_ack; combinational.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Requests are sampled only in this state.
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner, latch its address, we and wdata, and go to ISSUE.
- **Arbitration**
  - Data wins by default, since it is the older instruction.
  - Exception: when starve_cnt == STARVE and both requests are high, fetch wins.
- **starve_cnt**
  - Width is clog2(STARVE+1).
  - Increments, saturating, on each data grant made while if_req=1.
  - Clears on every fetch grant.
- **ISSUE**
  - mem_en=1 and mem_addr/mem_wdata are driven from the latches.
  - mem_rw=0 for a data write, 1 otherwise.
  - Write: next state is RESP, with no wait.
  - Read: next state is WAIT with wait_cnt=LAT-1.
- **WAIT**
  - Decrement wait_cnt.
  - When wait_cnt==0, capture mem_rdata into the winner's rdata register and go to RESP.
- **RESP**
  - Assert the winner's ack for one cycle; rdata is held stable.
  - Requests are ignored in this state.
  - Next state is IDLE.
- **Requester contract**
  - The requester advances on ack and may present its next request in the following cycle.
  - Dropping req before ack is a protocol violation: the access still completes and the ack still pulses.
- **Reset (reset=0)**
  - State returns to IDLE immediately.
  - mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0.
  - if_ack=dm_ack=0, if_rdata=dm_rdata=0.
  - starve_cnt=0, wait_cnt=0.
  - An in-flight read is discarded and no ack is issued for it.
  - A write whose ISSUE cycle already completed is committed by memory; the arbiter does not track it.

## Timing
- Let request-visible-in-IDLE be cycle c.
- ISSUE occurs at c+1.
- Read: mem_rdata is valid at c+1+LAT and is captured at the end of that cycle. ack is high at c+LAT+2.
- Write: ack is high at c+2.
- The earliest next IDLE is the cycle after RESP.
- Throughput:
  - Back-to-back reads: one per LAT+3 cycles.
  - Back-to-back writes: one per 3 cycles.
- mem_* outputs and acks are registered. Stalls are combinational from req and the registered ack.
- stall_* is low in the ack cycle, so the pipeline register loads at that edge.

## Structure
- **proc_pkg**
  - State enum: ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP.
  - Owner encoding: OWN_IF=1'b0, OWN_DM=1'b1.
  - Memory direction constants: MEM_RD=1'b1, MEM_WR=1'b0.
- **Sub-module:** `wait_counter`, a loadable down-counter with a zero flag, parameterised by LAT. It is reused for other multi-cycle units.

## Test plan
- **Single fetch read (LAT=2)**
  - Stimulus: if_req at cycle 0, if_addr=0x00010, mem_rdata=0xBEEF at cycle 3.
  - Response: mem_en=1, mem_rw=1, mem_addr=0x00010 at cycle 1. if_ack=1 and if_rdata=0xBEEF at cycle 4. stall_if=1 in cycles 0–3 and 0 in cycle 4.
- **Data write**
  - Stimulus: dm_req=1, dm_we=1, dm_addr=0x000A5, dm_wdata=0x1234 at cycle 0.
  - Response: mem_en=1, mem_rw=0 with that address and data at cycle 1. dm_ack at cycle 2. No if_ack.
- **Simultaneous requests (both reads, LAT=2)**
  - Stimulus: both requests at cycle 0.
  - Response: dm_ack at cycle 4. Fetch ISSUE at cycle 6. if_ack at cycle 9.
- **Starvation guard (STARVE=4)**
  - Stimulus: dm_req held with back-to-back writes and if_req held from cycle 0.
  - Response: data acks at cycles 2, 5, 8, 11. The fifth grant goes to fetch. starve_cnt returns to 0.
- **Reset mid-read**
  - Stimulus: reset=0 during WAIT.
  - Response: all outputs take their reset values asynchronously. After release with no requests, no ack ever pulses.
- **LAT=1 build**
  - Stimulus: fetch read at cycle 0.
  - Response: mem_rdata sampled at cycle 2. if_ack at cycle 3.
